mux_seln_reg: RTL and testbench

//  N-input, dw-bit channel selector with valid/ready handshake and one registered output stage.

---
 rtl/mux_pkg.sv | 27 ++
 rtl/mux_rr_arb.sv | 36 +++
 rtl/mux_seln_reg.sv | 119 +++++++++++
 tb/tb_mux_seln_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux_seln_reg channel selector.
//   clog2        : ceiling log2 of a positive integer
//   sel_width    : width of the select / source-channel fields for n channels
//   out_state_t  : output register occupancy state
// Build option: MUX_SELN_RR_EN is undefined by default, which gives fixed
// select from the sel port. Defining it switches the top to round-robin
// arbitration and the sel port is ignored.
package mux_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // n_in >= 2, so the select field is always at least one bit wide.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux_rr_arb.sv
// Combinational round-robin arbiter.
//   req     in  n_in  request per channel
//   ptr     in  sw    highest-priority channel this cycle (0..n_in-1)
//   gnt_idx out sw    first requesting channel scanning ptr, ptr+1, ... mod n_in
//   gnt_any out 1     at least one request is set (gnt_idx is valid)
// The pointer register lives in the instantiating module.
import mux_pkg::*;

module mux_rr_arb #(
  parameter int n_in = 4,
  parameter int sw   = sel_width(n_in)
) (
  input  logic [n_in-1:0] req,
  input  logic [sw-1:0]   ptr,
  output logic [sw-1:0]   gnt_idx,
  output logic            gnt_any
);

  int idx;

  // Scan from the farthest position back toward ptr so the closest
  // requester to ptr is the last one written and therefore wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = n_in - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % n_in;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[sw-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_seln_reg.sv
// N-input channel selector with valid/ready handshake and one registered
// output stage. Reports the source channel of each registered word.
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   IN_DATA    in   n_in*dw  channel k at [k*dw +: dw]
//   IN_VALID   in   n_in     per-channel valid
//   IN_READY   out  n_in     per-channel ready (combinational)
//   sel        in   sw       fixed-mode channel select
//   OUT        out  dw       registered data
//   OUT_VALID  out  1        output register holds a word
//   OUT_READY  in   1        downstream accepts OUT this cycle
//   OUT_CH     out  sw       channel that produced OUT
// Build option MUX_SELN_RR_EN: when defined, a round-robin arbiter replaces
// the sel port as the channel chooser.
import mux_pkg::*;

module mux_seln_reg #(
  parameter  int dw   = 'h10,
  parameter  int n_in = 4,
  localparam int sw   = sel_width(n_in)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [n_in*dw-1:0]   IN_DATA,
  input  logic [n_in-1:0]      IN_VALID,
  output logic [n_in-1:0]      IN_READY,
  input  logic [sw-1:0]        sel,
  output logic [dw-1:0]        OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [sw-1:0]        OUT_CH
);

  // state    | meaning
  // ST_EMPTY | output register holds no word
  // ST_FULL  | output register holds a word for downstream
  out_state_t     r_state, w_state_nxt;
  logic [dw-1:0]  r_out;
  logic [sw-1:0]  r_ch;
  logic           w_slot_free;
  logic           w_c_ok;
  logic           w_accept;
  logic [sw-1:0]  w_c;
  logic [dw-1:0]  w_data;

  assign OUT_VALID   = (r_state == ST_FULL);
  assign OUT         = r_out;
  assign OUT_CH      = r_ch;
  assign w_slot_free = !OUT_VALID || OUT_READY;

`ifdef MUX_SELN_RR_EN
  logic [sw-1:0] r_ptr;
  logic          w_unused_sel;
  assign w_unused_sel = ^sel;

  mux_rr_arb #(.n_in(n_in), .sw(sw)) u_arb (
    .req     (IN_VALID),
    .ptr     (r_ptr),
    .gnt_idx (w_c),
    .gnt_any (w_c_ok)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_accept)
      r_ptr <= (int'(w_c) == n_in - 1) ? '0 : w_c + sw'(1);
  end
`else
  // With non-power-of-2 n_in, out-of-range sel values choose nothing.
  assign w_c    = sel;
  assign w_c_ok = (int'(sel) < n_in);
`endif

  // Decode by comparison rather than indexing so an out-of-range w_c
  // never addresses a nonexistent channel.
  always_comb begin
    IN_READY = '0;
    w_data   = '0;
    for (int k = 0; k < n_in; k++) begin
      if (w_c == sw'(k)) begin
        w_data = IN_DATA[k*dw +: dw];
        if (!rst && w_slot_free && w_c_ok)
          IN_READY[k] = 1'b1;
      end
    end
  end

  assign w_accept = |(IN_READY & IN_VALID);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept)               w_state_nxt = ST_FULL;
      ST_FULL:  if (OUT_READY && !w_accept) w_state_nxt = ST_EMPTY;
      default:                              w_state_nxt = ST_EMPTY;
    endcase
  end

  // OUT and OUT_CH only change on a load, so they are bit-stable while
  // stalled and keep their last value after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_ch  <= '0;
    end else if (w_accept) begin
      r_out <= w_data;
      r_ch  <= w_c;
    end
  end

endmodule

// File: tb/tb_mux_seln_reg.sv
module tb_mux_seln_reg;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [1:0]      sel;
  logic [DW-1:0]   out_w;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_ch;

  logic [N3*DW-1:0] in_data3;
  logic [N3-1:0]    in_valid3;
  logic [N3-1:0]    in_ready3;
  logic [1:0]       sel3;
  logic [DW-1:0]    out3;
  logic             out_valid3;
  logic [1:0]       out_ch3;

  always #5 clk = ~clk;

  mux_seln_reg #(.dw(DW), .n_in(N)) u_dut (
    .clk(clk), .rst(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .sel(sel), .OUT(out_w), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_CH(out_ch)
  );

  mux_seln_reg #(.dw(DW), .n_in(N3)) u_dut3 (
    .clk(clk), .rst(rst), .IN_DATA(in_data3), .IN_VALID(in_valid3),
    .IN_READY(in_ready3), .sel(sel3), .OUT(out3), .OUT_VALID(out_valid3),
    .OUT_READY(1'b1), .OUT_CH(out_ch3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // Reference model: the register contents as a few plain variables.
  logic [DW-1:0] m_out;
  logic          m_valid;
  int            m_ch;
  int            m_ptr;

  // Which channel the selector picks now, or -1 when none.
  function automatic int chosen();
`ifdef MUX_SELN_RR_EN
    for (int i = 0; i < N; i++)
      if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
`else
    return (int'(sel) < N) ? int'(sel) : -1;
`endif
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int c;
    c = chosen();
    if (rst || c < 0 || !(!m_valid || out_ready)) return '0;
    return N'(1) << c;
  endfunction

  task automatic model_edge();
    int c;
    c = chosen();
    if (rst) begin
      m_out = '0; m_valid = 1'b0; m_ch = 0; m_ptr = 0;
    end else if (c >= 0 && (!m_valid || out_ready) && in_valid[c]) begin
      m_out   = in_data[c*DW +: DW];
      m_ch    = c;
      m_valid = 1'b1;
      m_ptr   = (c + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Inputs are set before the call; checks land 1 ns after input changes
  // and 1 ns after the rising edge.
  task automatic cycle();
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out", 64'(out_w), 64'(m_out));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
  endtask

  initial begin
    m_out = '0; m_valid = 1'b0; m_ch = 0; m_ptr = 0;
    rst = 1'b1; in_data = '0; in_valid = '1; sel = 2'd0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '1; sel3 = 2'd3;

    // reset for two clocks with every channel valid
    cycle();
    cycle();
    chk("rst_out", 64'(out_w), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ch", 64'(out_ch), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h0);

    // single fixed-select load from channel 2
    rst = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = '0;
    in_data[2*DW +: DW] = 16'hA5A5;
    #1;
    chk("t2_ready", 64'(in_ready), 64'h4);
    cycle();
    chk("t2_out", 64'(out_w), 64'hA5A5);
    chk("t2_ch", 64'(out_ch), 64'h2);
    chk("t2_valid", 64'(out_valid), 64'h1);

    // backpressure: load, stall 5 clk while sel/data churn, then drain+load
    in_valid = 4'b0001; sel = 2'd0; in_data[0 +: DW] = 16'h1111;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = '1; sel = 2'(i); in_data = {$urandom, $urandom};
      cycle();
      chk("t3_stall_out", 64'(out_w), 64'h1111);
      chk("t3_stall_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1; in_valid = 4'b1000; sel = 2'd3; in_data[3*DW +: DW] = 16'h3333;
    cycle();
    chk("t3_reload_out", 64'(out_w), 64'h3333);
    chk("t3_reload_valid", 64'(out_valid), 64'h1);

    // streaming from channel 1, one word per clock
    sel = 2'd1; in_valid = 4'b0010;
    for (int v = 1; v <= 8; v++) begin
      in_data[1*DW +: DW] = 16'(v);
      cycle();
      chk("t4_stream_out", 64'(out_w), 64'(v));
      chk("t4_stream_ch", 64'(out_ch), 64'h1);
      chk("t4_stream_valid", 64'(out_valid), 64'h1);
    end
    in_valid = '0;
    cycle();
    chk("t4_drained", 64'(out_valid), 64'h0);
    chk("t4_hold_out", 64'(out_w), 64'h8);

`ifndef MUX_SELN_RR_EN
    // three channels: sel=3 chooses nothing even with all valid
    sel3 = 2'd3; in_valid3 = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_ready3", 64'(in_ready3), 64'h0);
      @(posedge clk); #1;
      chk("t5_valid3", 64'(out_valid3), 64'h0);
    end
    sel3 = 2'd1; in_data3[1*DW +: DW] = 16'h1234;
    @(posedge clk); #1;
    chk("t5_load3", 64'(out3), 64'h1234);
    chk("t5_ch3", 64'(out_ch3), 64'h1);
`else
    // round-robin grant order
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'b1111; in_data = 64'h4444_3333_2222_1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t6_rr_all", 64'(out_ch), 64'(i % 4));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_rr_1010", 64'((i == 1) ? 3 : 1), 64'(out_ch));
    end
    in_valid = 4'b1111;
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    chk("t6_rr_after_rst", 64'(out_ch), 64'h0);
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      in_data   = {$urandom, $urandom};
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
